// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU memory slice: default widths, loader state
// encoding and a small decode helper.
package cpu_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

  // CPU strobes only take effect while the loader is not holding the memory.
  function automatic logic strobes_enabled(input load_state_t state);
    return state == IDLE;
  endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port RAM: one synchronous write port, combinational read of the
// addressed word. Contents are never reset.
module ram_sp
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/memory_unit.sv
// CPU memory unit: MAR, RAM and read register on a shared bus, plus an
// optional external program loader compiled in when PROG_LOADER_EN is defined.
module memory_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic              nLma,
  input  logic              nLmd,
  input  logic              nLr,
  input  logic              nCE,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic [ADDR_W-1:0] mar_out
);

  logic [ADDR_W-1:0] mar_r;
  logic [DATA_W-1:0] rd_q_r;
  load_state_t       state_s;
  logic              cpu_idle_s;
  logic              load_we_s;
  logic [ADDR_W-1:0] load_addr_s;
  logic [DATA_W-1:0] load_data_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic [DATA_W-1:0] ram_rdata_s;

`ifdef PROG_LOADER_EN
  load_state_t       state_r;
  logic [ADDR_W-1:0] count_r;

  // Loader FSM; an abort or reset keeps already written words, count restarts on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      count_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (prog_mode) begin
            state_r <= LOAD;
            count_r <= '0;
          end
        end
        LOAD: begin
          if (prog_valid) begin
            count_r <= count_r + ADDR_W'(1);
          end
          if (!prog_mode) begin
            state_r <= IDLE;
          end else if (prog_valid && (count_r == '1)) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          if (!prog_mode) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          count_r <= '0;
        end
      endcase
    end
  end

  assign state_s     = state_r;
  assign load_we_s   = (state_r == LOAD) && prog_valid;
  assign load_addr_s = count_r;
  assign load_data_s = prog_data;
`else
  logic unused_s;

  assign state_s     = IDLE;
  assign load_we_s   = 1'b0;
  assign load_addr_s = '0;
  assign load_data_s = '0;
  assign unused_s    = ^{prog_mode, prog_valid, prog_data};
`endif

  assign cpu_idle_s = strobes_enabled(state_s);

  // RAM port steering: the loader owns address/data while loading.
  always_comb begin
    ram_addr_s  = mar_r;
    ram_wdata_s = bus_in;
    ram_we_s    = 1'b0;
    if (rst) begin
      ram_we_s = 1'b0;
    end else if (state_s == LOAD) begin
      ram_addr_s  = load_addr_s;
      ram_wdata_s = load_data_s;
      ram_we_s    = load_we_s;
    end else if (cpu_idle_s) begin
      ram_we_s = ~nLmd;
    end else begin
      ram_we_s = 1'b0;
    end
  end

  ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  // MAR and read register; rd_q samples the pre-write word (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      mar_r  <= '0;
      rd_q_r <= '0;
    end else begin
      if (cpu_idle_s && !nLma) begin
        mar_r <= bus_in[ADDR_W-1:0];
      end
      if (cpu_idle_s && !nLr) begin
        rd_q_r <= ram_rdata_s;
      end
    end
  end

  // Bus driver.
  always_comb begin
    bus_out = '0;
    bus_oe  = 1'b0;
    if (cpu_idle_s && !nCE) begin
      bus_out = rd_q_r;
      bus_oe  = 1'b1;
    end else begin
      bus_out = '0;
      bus_oe  = 1'b0;
    end
  end

  assign prog_ready = (state_s == LOAD);
  assign prog_done  = (state_s == DONE);
  assign mar_out    = mar_r;

endmodule
